// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run/step controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package riswitch_ctrl_pkg;

  localparam int CYCLE_W = 32;

  typedef enum logic [2:0] {
    RST,
    IDLE,
    STEP,
    RUN,
    HALTED
  } run_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v,
                                                 input logic              en);
    if (en && (v != {CYCLE_W{1'b1}})) begin
      return v + CYCLE_W'(1);
    end
    return v;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board/CPU-side signal bundle of the run controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
// master: the controller (takes buttons and CPU status, drives tick/reset/LED status).
// slave : the board/CPU side (drives buttons and CPU status, takes tick/reset/LED status).
interface cpu_run_ctrl_if;
  import riswitch_ctrl_pkg::*;

  logic               btn_step;
  logic               btn_run;
  logic               btn_rst;
  logic               halt;
  logic               trap;
  logic               cpu_tick;
  logic               cpu_reset;
  logic               running;
  logic               halted_ok;
  logic               halted_bad;
  logic [CYCLE_W-1:0] cycle_count;

  modport master (
    input  btn_step, btn_run, btn_rst, halt, trap,
    output cpu_tick, cpu_reset, running, halted_ok, halted_bad, cycle_count
  );

  modport slave (
    output btn_step, btn_run, btn_rst, halt, trap,
    input  cpu_tick, cpu_reset, running, halted_ok, halted_bad, cycle_count
  );

endinterface

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, level debouncer, rising-edge press pulse.
// Latency: raw edge to press pulse = 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; press is a one-cycle pulse, releases produce nothing.
// Ports: clock, reset (sync, active high), raw (async button), press (one-cycle pulse).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // cnt_q counts consecutive cycles in which the synchronized input disagrees
  // with the accepted level; any agreeing cycle restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press   <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press   <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer: buttons -> one-cycle CPU clock enable and stretched CPU reset.
// Latency: press pulse -> state/tick change on the next edge; all outputs registered.
// Backpressure: none; presses are consumed or ignored in the cycle they arrive.
// Ports: clock, reset (sync, active high), bus (cpu_run_ctrl_if.master: buttons,
// halt/trap in; cpu_tick, cpu_reset, running, halted_ok/bad, cycle_count out).
module cpu_run_ctrl
  import riswitch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int RUN_DIV         = 1,
  parameter int RST_CYCLES      = 4
) (
  input  logic           clock,
  input  logic           reset,
  cpu_run_ctrl_if.master bus
);

  localparam int DIV_W     = 16;
  localparam int RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic step_press, run_press, rst_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clock(clock), .reset(reset), .raw(bus.btn_step), .press(step_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clock(clock), .reset(reset), .raw(bus.btn_run), .press(run_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
    .clock(clock), .reset(reset), .raw(bus.btn_rst), .press(rst_press));

  run_state_t           state_q, state_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick_d;
  logic                 tick_q, cpu_reset_q, running_q, ok_q, bad_q;
  logic [CYCLE_W-1:0]   count_q, count_d;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    div_d     = '0;
    tick_d    = 1'b0;

    case (state_q)
      RST: begin
        if (rst_cnt_q == RST_CNT_W'(RST_CYCLES - 1)) state_d = IDLE;
        else rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
      end
      IDLE: begin
        if (bus.halt)       state_d = HALTED;
        else if (run_press) state_d = RUN;
        else if (step_press) state_d = STEP;
      end
      STEP: state_d = IDLE;
      RUN: begin
        if (bus.halt)       state_d = HALTED;
        else if (run_press) state_d = IDLE;
      end
      HALTED: state_d = HALTED;
      default: state_d = RST;
    endcase

    // A reset press overrides everything and restarts the reset stretch.
    if (rst_press) begin
      state_d   = RST;
      rst_cnt_d = '0;
    end

    // Ticks are decided from the next state so they start and stop on the
    // same edge as the state change; div_q counts cycles since the last tick.
    if (state_d == RUN) begin
      if ((state_q != RUN) || (div_q == DIV_W'(RUN_DIV - 1))) tick_d = 1'b1;
      else div_d = div_q + DIV_W'(1);
    end else if (state_d == STEP) begin
      tick_d = 1'b1;
    end

    // The counter follows the registered tick, so a tick issued in the cycle
    // halt rises is still counted on the following edge.
    count_d = (state_d == RST) ? '0 : sat_inc(count_q, tick_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RST;
      rst_cnt_q   <= '0;
      div_q       <= '0;
      tick_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      ok_q        <= 1'b0;
      bad_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      cpu_reset_q <= (state_d == RST);
      running_q   <= (state_d == RUN);
      count_q     <= count_d;
      if (state_d == RST) begin
        ok_q  <= 1'b0;
        bad_q <= 1'b0;
      end else if ((state_d == HALTED) && (state_q != HALTED)) begin
        ok_q  <= bus.trap;
        bad_q <= !bus.trap;
      end
    end
  end

  assign bus.cpu_tick    = tick_q;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.running     = running_q;
  assign bus.halted_ok   = ok_q;
  assign bus.halted_bad  = bad_q;
  assign bus.cycle_count = count_q;

endmodule
